mipi_tx_sync_gen: RTL and testbench
===================================

# mipi_tx_sync_gen

Transmit-side sync packet generator for the MIPI DSI video path. It watches pixel-domain Vsync/Hsync levels and emits DSI sync short-packet commands over a valid/ready command interface to the Tx packet assembler. Command types are VSync Start 0x01, VSync End 0x11, HSync Start 0x21 and HSync End 0x31. It sits between the video timing generator and the Tx command mux. It mirrors the Rx-side Vsync detection and keeps per-frame line and frame counts for status.

## Interface
Parameters:
- VC, 2'd0: virtual channel driven on Tx_cmd_vc.
- LINE_W, 12: width of the line counter.
- FRAME_W, 16: width of the frame counter.

Ports:
- CLKn  in  1  single clock; all logic on the rising edge.
- RSTn  in  1  reset, asynchronous assert, active-low.
- Vsync  in  1  frame sync level from the timing generator, active high.
- Hsync  in  1  line sync level, active high.
- Tx_cmd_ready  in  1  assembler accepts a command this cycle.
- Tx_cmd_valid  out  1  command offered.
- Tx_cmd_data_type  out  6  DSI data type of the offered command.
- Tx_cmd_vc  out  2  constant VC.
- Line_cnt  out  LINE_W  count of HSS transferred since the last VSS.
- Frame_cnt  out  FRAME_W  count of VSS transferred.
- Overflow  out  1  sticky flag: a sync event was lost.

## Operation
- Edge detection: Vsync and Hsync are registered once. A rise is input high while the registered copy is low. A fall is the reverse.
- Each rise or fall sets a pending bit: P_VSS on Vsync rise, P_VSE on Vsync fall, P_HSS on Hsync rise, P_HSE on Hsync fall.
- FSM states:
  - IDLE: if any pending bit is set, load the highest-priority one into Tx_cmd_data_type, clear that bit, and go to SEND.
  - SEND: hold Tx_cmd_valid high with data type stable until Tx_cmd_valid & Tx_cmd_ready. On that handshake edge:
    - if another pending bit is set, load it in the same edge and stay in SEND (back-to-back, valid stays high);
    - otherwise go to IDLE.
- Priority order: VSS > VSE > HSS > HSE.
- A new event on the edge its pending bit is being cleared by a load re-sets that bit. No overflow in this case.
- An event arriving while its pending bit is already set sets Overflow. The event is dropped. Overflow clears only on reset.
- Counters update only on handshake:
  - VSS transferred: Frame_cnt += 1 (wraps modulo 2^FRAME_W) and Line_cnt cleared to 0.
  - HSS transferred: Line_cnt += 1, saturating at all-ones.
- Tx_cmd_vc is always VC.

## Timing
- Reset values: Tx_cmd_valid 0, Tx_cmd_data_type 0, Line_cnt 0, Frame_cnt 0, Overflow 0. Edge registers and pending bits are 0; FSM state is IDLE.
- Latency: Vsync first sampled high at edge k (low at k-1) sets P_VSS at k. Tx_cmd_valid is high after edge k+1.
- Throughput: one command per cycle while Tx_cmd_ready is held high.
- Valid must not drop and data type must not change before the handshake.
- Simultaneous Vsync rise and Hsync rise: VSS is sent first, then HSS. That HSS counts as line 1 of the new frame.
- Reset asserted mid-SEND: valid drops asynchronously. The pending command is discarded and not re-sent after reset.
- Overflow and counter updates are visible the cycle after the causing edge.

## Configuration
- MIPI_TX_SYNC_END_EN defined: VSE and HSE are generated as described above.
- MIPI_TX_SYNC_END_EN undefined: falling edges are ignored. P_VSE and P_HSE do not exist, and only 0x01 and 0x21 are ever emitted (sync-pulse-less event mode). Counters and Overflow are unchanged.

## Structure
- Shared package mipi_dsi_pkg holds:
  - data type constants DT_VSS=6'h01, DT_VSE=6'h11, DT_HSS=6'h21, DT_HSE=6'h31;
  - FSM state enum {IDLE, SEND}.
- The Rx Vsync detector uses the same DT_VSS constant.
- One sub-module, mipi_tx_edge_det: 1-bit register plus rise/fall outputs, instanced for Vsync and Hsync.

## Test plan
- Ready tied high; Vsync 0→1 at edge 10 → valid high after edge 11 with type 0x01; Frame_cnt=1 and Line_cnt=0 after the handshake.
- Vsync and Hsync rise on the same edge, ready high → 0x01 then 0x21 on consecutive cycles; Line_cnt=1.
- Ready low for 5 cycles during SEND of 0x21 → valid and type held all 5 cycles; one transfer only; Line_cnt increments once.
- Ready low; two Hsync rise pulses while P_HSS is still pending → Overflow=1; exactly one HSS sent after ready rises.
- With MIPI_TX_SYNC_END_EN: one Vsync pulse of 3 cycles, ready high → 0x01 then 0x11. Without the macro → only 0x01.
- RSTn low while valid high with type 0x21 → valid 0 immediately; after release no command is issued and all outputs are 0.

Source files
------------

// File: rtl/mipi_dsi_pkg.sv
// Shared MIPI DSI definitions: sync short-packet data types, pending-bit
// indices and the Tx sync generator FSM state type.
package mipi_dsi_pkg;

    // DSI sync short-packet data types (also used by the Rx Vsync detector)
    localparam logic [5:0] DT_VSS = 6'h01;
    localparam logic [5:0] DT_VSE = 6'h11;
    localparam logic [5:0] DT_HSS = 6'h21;
    localparam logic [5:0] DT_HSE = 6'h31;

    // Bit positions in the pending-event vector, highest priority first
    localparam int P_VSS = 3;
    localparam int P_VSE = 2;
    localparam int P_HSS = 1;
    localparam int P_HSE = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } sync_state_e;

endpackage : mipi_dsi_pkg

// File: rtl/mipi_tx_edge_det.sv
// Single-bit level sampler with combinational rise/fall strobes relative to
// the previously registered level.
module mipi_tx_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic din_d;
    logic din_q;

    // Next value of the delayed copy is simply the current input level
    always_comb begin
        din_d = din;
    end

    // One-cycle delayed copy of the input level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_d;
        end
    end

    assign rise = din & ~din_q;
    assign fall = ~din & din_q;

endmodule : mipi_tx_edge_det

// File: rtl/mipi_tx_sync_gen.sv
// Tx sync short-packet generator: turns Vsync/Hsync level edges into DSI
// sync commands on a valid/ready interface, with line/frame status counters
// and a sticky overflow flag for lost events.
// Build option: define MIPI_TX_SYNC_END_EN to also emit VSync End / HSync End
// on falling edges; without it only VSS and HSS are generated.
module mipi_tx_sync_gen
    import mipi_dsi_pkg::*;
#(
    parameter logic [1:0] VC      = 2'd0,
    parameter int         LINE_W  = 12,
    parameter int         FRAME_W = 16
) (
    input  logic               CLKn,
    input  logic               RSTn,
    input  logic               Vsync,
    input  logic               Hsync,
    input  logic               Tx_cmd_ready,
    output logic               Tx_cmd_valid,
    output logic [5:0]         Tx_cmd_data_type,
    output logic [1:0]         Tx_cmd_vc,
    output logic [LINE_W-1:0]  Line_cnt,
    output logic [FRAME_W-1:0] Frame_cnt,
    output logic               Overflow
);

    logic v_rise, v_fall, h_rise, h_fall;
    logic [3:0] ev;

    sync_state_e        state_q, state_d;
    logic [5:0]         type_q, type_d;
    logic [3:0]         pend_q, pend_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               ovf_q, ovf_d;
    logic               hs;
    logic [3:0]         clr;

    mipi_tx_edge_det u_vsync_det (
        .clk   (CLKn),
        .rst_n (RSTn),
        .din   (Vsync),
        .rise  (v_rise),
        .fall  (v_fall)
    );

    mipi_tx_edge_det u_hsync_det (
        .clk   (CLKn),
        .rst_n (RSTn),
        .din   (Hsync),
        .rise  (h_rise),
        .fall  (h_fall)
    );

`ifdef MIPI_TX_SYNC_END_EN
    assign ev = {v_rise, v_fall, h_rise, h_fall};
`else
    // Falling edges carry no meaning in event mode; the end-pending bits
    // therefore never set and fold away as constants.
    logic unused_fall;
    assign unused_fall = v_fall ^ h_fall;
    assign ev = {v_rise, 1'b0, h_rise, 1'b0};
`endif

    // Next-state, command load, pending bookkeeping and counter updates
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        line_d  = line_q;
        frame_d = frame_q;
        ovf_d   = ovf_q;
        clr     = '0;
        hs      = (state_q == SEND) && Tx_cmd_ready;

        if (hs) begin
            if (type_q == DT_VSS) begin
                frame_d = frame_q + 1'b1;
                line_d  = '0;
            end else if (type_q == DT_HSS) begin
                if (line_q != {LINE_W{1'b1}}) begin
                    line_d = line_q + 1'b1;
                end
            end
        end

        // A load happens from IDLE or on the handshake edge (back-to-back)
        if ((state_q == IDLE) || hs) begin
            if (pend_q[P_VSS]) begin
                clr[P_VSS] = 1'b1;
                type_d     = DT_VSS;
                state_d    = SEND;
            end else if (pend_q[P_VSE]) begin
                clr[P_VSE] = 1'b1;
                type_d     = DT_VSE;
                state_d    = SEND;
            end else if (pend_q[P_HSS]) begin
                clr[P_HSS] = 1'b1;
                type_d     = DT_HSS;
                state_d    = SEND;
            end else if (pend_q[P_HSE]) begin
                clr[P_HSE] = 1'b1;
                type_d     = DT_HSE;
                state_d    = SEND;
            end else begin
                state_d = IDLE;
            end
        end

        // An event is lost only if its bit stays set through this edge;
        // one being loaded right now frees its slot for the new event.
        if (|(ev & pend_q & ~clr)) begin
            ovf_d = 1'b1;
        end
        pend_d = (pend_q & ~clr) | ev;
    end

    // State, command and status registers
    always_ff @(posedge CLKn or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            type_q  <= '0;
            pend_q  <= '0;
            line_q  <= '0;
            frame_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            pend_q  <= pend_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Tx_cmd_valid     = (state_q == SEND);
    assign Tx_cmd_data_type = type_q;
    assign Tx_cmd_vc        = VC;
    assign Line_cnt         = line_q;
    assign Frame_cnt        = frame_q;
    assign Overflow         = ovf_q;

endmodule : mipi_tx_sync_gen

// File: tb/tb_mipi_tx_sync_gen.sv
// Directed testbench for mipi_tx_sync_gen (default LINE_W/FRAME_W/VC).
// Expectations follow the MIPI_TX_SYNC_END_EN setting of the build.
module tb_mipi_tx_sync_gen;

    logic        CLKn;
    logic        RSTn;
    logic        Vsync;
    logic        Hsync;
    logic        Tx_cmd_ready;
    logic        Tx_cmd_valid;
    logic [5:0]  Tx_cmd_data_type;
    logic [1:0]  Tx_cmd_vc;
    logic [11:0] Line_cnt;
    logic [15:0] Frame_cnt;
    logic        Overflow;

    int n_chk  = 0;
    int n_fail = 0;

    logic [5:0] log_q[$];

    mipi_tx_sync_gen dut (
        .CLKn             (CLKn),
        .RSTn             (RSTn),
        .Vsync            (Vsync),
        .Hsync            (Hsync),
        .Tx_cmd_ready     (Tx_cmd_ready),
        .Tx_cmd_valid     (Tx_cmd_valid),
        .Tx_cmd_data_type (Tx_cmd_data_type),
        .Tx_cmd_vc        (Tx_cmd_vc),
        .Line_cnt         (Line_cnt),
        .Frame_cnt        (Frame_cnt),
        .Overflow         (Overflow)
    );

    initial CLKn = 1'b0;
    always #5 CLKn = ~CLKn;

    // Record every transferred command type
    always @(negedge CLKn) begin
        if (RSTn && Tx_cmd_valid && Tx_cmd_ready) begin
            log_q.push_back(Tx_cmd_data_type);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLKn);
            #1;
        end
    endtask

    function automatic logic [5:0] log_at(input int idx);
        if (log_q.size() > idx) return log_q[idx];
        return 6'h3f;
    endfunction

    initial begin
        RSTn         = 1'b0;
        Vsync        = 1'b0;
        Hsync        = 1'b0;
        Tx_cmd_ready = 1'b0;
        tick(3);

        // Reset state
        chk("rst_valid", Tx_cmd_valid, 0);
        chk("rst_type",  Tx_cmd_data_type, 0);
        chk("rst_line",  Line_cnt, 0);
        chk("rst_frame", Frame_cnt, 0);
        chk("rst_ovf",   Overflow, 0);
        chk("vc",        Tx_cmd_vc, 0);
        RSTn = 1'b1;
        tick(2);

        // Test 1: single VSS, ready high
        log_q.delete();
        Tx_cmd_ready = 1'b1;
        Vsync        = 1'b1;
        tick();
        chk("t1_valid_k", Tx_cmd_valid, 0);
        tick();
        chk("t1_valid_k1", Tx_cmd_valid, 1);
        chk("t1_type",     Tx_cmd_data_type, 6'h01);
        tick();
        chk("t1_valid_done", Tx_cmd_valid, 0);
        chk("t1_frame", Frame_cnt, 1);
        chk("t1_line",  Line_cnt, 0);
        chk("t1_log_n", log_q.size(), 1);

        // Test 2: simultaneous Vsync/Hsync rise
        Vsync = 1'b0;
        Hsync = 1'b0;
        tick(4);
        log_q.delete();
        Vsync = 1'b1;
        Hsync = 1'b1;
        tick(2);
        chk("t2_valid_vss", Tx_cmd_valid, 1);
        chk("t2_type_vss",  Tx_cmd_data_type, 6'h01);
        tick();
        chk("t2_valid_hss", Tx_cmd_valid, 1);
        chk("t2_type_hss",  Tx_cmd_data_type, 6'h21);
        chk("t2_frame",     Frame_cnt, 2);
        chk("t2_line_mid",  Line_cnt, 0);
        tick();
        chk("t2_valid_done", Tx_cmd_valid, 0);
        chk("t2_line", Line_cnt, 1);
        chk("t2_log0", log_at(0), 6'h01);
        chk("t2_log1", log_at(1), 6'h21);

        // Test 3: back-pressure during HSS
        Vsync = 1'b0;
        Hsync = 1'b0;
        tick(4);
        log_q.delete();
        Tx_cmd_ready = 1'b0;
        Hsync        = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_hold_valid%0d", i), Tx_cmd_valid, 1);
            chk($sformatf("t3_hold_type%0d", i),  Tx_cmd_data_type, 6'h21);
            tick();
        end
        chk("t3_line_held", Line_cnt, 1);
        Tx_cmd_ready = 1'b1;
        tick();
        chk("t3_valid_done", Tx_cmd_valid, 0);
        chk("t3_line", Line_cnt, 2);
        tick(3);
        chk("t3_log_n", log_q.size(), 1);
        chk("t3_log0",  log_at(0), 6'h21);

        // Test 4: overflow on repeated Hsync while P_HSS pending
        Hsync = 1'b0;
        tick(4);
        log_q.delete();
        Tx_cmd_ready = 1'b0;
        Vsync        = 1'b1;
        tick(2);
        Hsync = 1'b1;
        tick();
        Hsync = 1'b0;
        tick();
        chk("t4_ovf_before", Overflow, 0);
        Hsync = 1'b1;
        tick();
        chk("t4_ovf_set",   Overflow, 1);
        chk("t4_valid_vss", Tx_cmd_valid, 1);
        chk("t4_type_vss",  Tx_cmd_data_type, 6'h01);
        Hsync = 1'b0;
        tick();
        Tx_cmd_ready = 1'b1;
        tick(6);
        chk("t4_log0", log_at(0), 6'h01);
        chk("t4_log1", log_at(1), 6'h21);
`ifdef MIPI_TX_SYNC_END_EN
        chk("t4_log_n", log_q.size(), 3);
        chk("t4_log2",  log_at(2), 6'h31);
`else
        chk("t4_log_n", log_q.size(), 2);
`endif
        chk("t4_frame",      Frame_cnt, 3);
        chk("t4_line",       Line_cnt, 1);
        chk("t4_ovf_sticky", Overflow, 1);

        // Test 5: Vsync pulse of 3 cycles
        Vsync = 1'b0;
        tick(4);
        log_q.delete();
        Vsync = 1'b1;
        tick(3);
        Vsync = 1'b0;
        tick(6);
        chk("t5_log0", log_at(0), 6'h01);
`ifdef MIPI_TX_SYNC_END_EN
        chk("t5_log_n", log_q.size(), 2);
        chk("t5_log1",  log_at(1), 6'h11);
`else
        chk("t5_log_n", log_q.size(), 1);
`endif
        chk("t5_frame", Frame_cnt, 4);
        chk("t5_line",  Line_cnt, 0);

        // Test 6: reset asserted mid-SEND of HSS
        Tx_cmd_ready = 1'b0;
        Hsync        = 1'b1;
        tick(2);
        chk("t6_valid_pre", Tx_cmd_valid, 1);
        chk("t6_type_pre",  Tx_cmd_data_type, 6'h21);
        RSTn = 1'b0;
        #1;
        chk("t6_valid_async", Tx_cmd_valid, 0);
        chk("t6_type_async",  Tx_cmd_data_type, 0);
        Hsync = 1'b0;
        tick(2);
        log_q.delete();
        RSTn         = 1'b1;
        Tx_cmd_ready = 1'b1;
        tick(5);
        chk("t6_valid_post", Tx_cmd_valid, 0);
        chk("t6_type_post",  Tx_cmd_data_type, 0);
        chk("t6_line_post",  Line_cnt, 0);
        chk("t6_frame_post", Frame_cnt, 0);
        chk("t6_ovf_post",   Overflow, 0);
        chk("t6_log_n",      log_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_mipi_tx_sync_gen
